sccb_cfg_seq: RTL and testbench
===============================

Name: sccb_cfg_seq

Overview:
- Sequencer that walks a camera register table and programs the OV sensor over SCCB.
- For each entry it issues an SCCB write, then a readback, and compares the result. A mismatch triggers a retry; retries exhausted latch an error.
- Sits between the power-up/reset logic and the SCCB master (write and read phases). The register table is an external combinational ROM indexed by this block.

Parameters:
- REG_NUM, 16, number of table entries (1..255).
- RETRY_MAX, 3, write+readback attempts per entry before error (1..7).
- DLY_UNIT, 50000, clk cycles per delay tick (1 ms at 50 MHz).
- VERIFY_EN, 1, 1 = readback/compare after each write; 0 = write only.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a configuration pass (ignored unless IDLE/DONE/ERR)
- tbl_idx  out  8  current table index to ROM
- tbl_data  in  16  ROM entry {reg_addr[15:8], reg_val[7:0]}, valid same cycle as tbl_idx
- sccb_req  out  1  one-cycle transaction request to SCCB master
- sccb_wr  out  1  1 = write, 0 = read; valid with sccb_req
- sccb_addr  out  8  sub-address; held from req until done
- sccb_wdata  out  8  write value; held from req until done
- sccb_done  in  1  one-cycle pulse when transaction ends
- sccb_rdata  in  8  read value, valid with sccb_done on a read
- busy  out  1  high from start accepted until DONE/ERR
- cfg_done  out  1  level, all entries programmed
- cfg_err  out  1  level, entry failed after RETRY_MAX attempts
- err_idx  out  8  index of failing entry (valid while cfg_err)

Behaviour:
- Reset: state IDLE. tbl_idx=0, sccb_req=0, sccb_wr=0, sccb_addr=0, sccb_wdata=0, busy=0, cfg_done=0, cfg_err=0, err_idx=0. Reset mid-transaction aborts immediately; there is no SCCB cleanup.
- IDLE/DONE/ERR + start: clear cfg_done, cfg_err, tbl_idx and the retry count; go to LOAD. busy rises the next cycle.
- LOAD (1 cycle): register tbl_data.
  - If addr==8'hFF: this is a delay entry; go to DELAY.
  - Otherwise go to WR.
- WR: assert sccb_req=1, sccb_wr=1 for exactly 1 cycle with the latched addr/val; go to WR_WAIT.
- WR_WAIT: wait for sccb_done.
  - VERIFY_EN=1: go to RD.
  - VERIFY_EN=0: go to NEXT.
- RD: assert sccb_req=1, sccb_wr=0 for 1 cycle; go to RD_WAIT.
- RD_WAIT: on sccb_done, capture sccb_rdata; go to CHECK.
- CHECK:
  - rdata==val: go to NEXT.
  - Else retry count +1. If count==RETRY_MAX: err_idx=tbl_idx, cfg_err=1, go to ERR. Otherwise go to WR (same entry).
- DELAY: count val*DLY_UNIT cycles, then go to NEXT. val==0 means no delay: go to NEXT on the following cycle. The counter width must hold 255*DLY_UNIT.
- NEXT:
  - tbl_idx==REG_NUM-1: go to DONE, cfg_done=1, busy=0.
  - Else tbl_idx+1, retry=0, go to LOAD.
- DONE/ERR: hold outputs. A new start re-runs the pass from index 0.
- sccb_done outside a WAIT state is ignored. start while busy is ignored.
- Entry 0x12 (COM7) with val bit7=1 is a soft reset, and the register self-clears. The table author must put a 0xFF delay entry after it; the sequencer does not special-case it. Readback of that entry is a known mismatch, so tables using it are run with VERIFY_EN=0.

Test Plan:
- REG_NUM=3, table {0x1100,0x1204,0x4010}, SCCB model echoes writes → 6 reqs alternating wr=1/0 with addr 0x11,0x11,0x12,0x12,0x40,0x40; cfg_done=1, busy=0, cfg_err=0.
- Model returns 0x05 for addr 0x12 on all reads, RETRY_MAX=3 → 3 write/read pairs on 0x12; cfg_err=1, err_idx=1, no access to 0x40.
- Model mismatches once then matches → exactly 2 writes to 0x12; pass completes with cfg_done=1.
- DLY_UNIT=10, table {0x1280,0xFF03,0x1100}, VERIFY_EN=0 → 30 cycles of no sccb_req between done of 0x12 and req of 0x11.
- Assert rst_n low during RD_WAIT → all outputs at reset values next cycle; a fresh start restarts at tbl_idx=0.
- start pulsed while busy, and spurious sccb_done in LOAD → no state disturbance; request sequence identical to the first scenario.

Source files
------------

// File: rtl/sccb_cfg_seq.sv
// -----------------------------------------------------------------------------
// sccb_cfg_seq
//   Walks an external register table and programs a camera sensor through an
//   SCCB master. Each table entry is written, optionally read back and
//   compared. A mismatch retries the entry, and repeated mismatches latch an
//   error. An entry whose address is 8'hFF is a delay of val*DLY_UNIT cycles.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             one-cycle pulse, starts a pass (only from IDLE/DONE/ERR)
//   tbl_idx/tbl_data  combinational ROM interface {reg_addr, reg_val}
//   sccb_req/sccb_wr  one-cycle request to the SCCB master, 1 = write
//   sccb_addr/wdata   sub-address and write value, held until sccb_done
//   sccb_done/rdata   transaction end pulse, read value valid with it
//   busy              pass in progress
//   cfg_done/cfg_err  pass completed / entry failed (levels)
//   err_idx           index of the failing entry
// -----------------------------------------------------------------------------
module sccb_cfg_seq #(
    parameter int unsigned REG_NUM   = 16,
    parameter int unsigned RETRY_MAX = 3,
    parameter int unsigned DLY_UNIT  = 50000,
    parameter int unsigned VERIFY_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  tbl_idx,
    input  logic [15:0] tbl_data,
    output logic        sccb_req,
    output logic        sccb_wr,
    output logic [7:0]  sccb_addr,
    output logic [7:0]  sccb_wdata,
    input  logic        sccb_done,
    input  logic [7:0]  sccb_rdata,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [7:0]  err_idx
);

    localparam int unsigned DLY_MAX   = 255 * DLY_UNIT;
    localparam int unsigned DLY_W     = $clog2(DLY_MAX + 1);
    localparam logic [7:0]  LAST_IDX  = 8'(REG_NUM - 1);
    localparam logic [2:0]  RETRY_LIM = 3'(RETRY_MAX);
    localparam logic [7:0]  DLY_ADDR  = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WR, S_WR_WAIT, S_RD, S_RD_WAIT,
        S_CHECK, S_DELAY, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t           state;
    logic [7:0]       rdata_q;
    logic [2:0]       retry;
    logic [DLY_W-1:0] dly_cnt;

    // Requests are raised on the transition into WR/RD so that sccb_req is a
    // registered one-cycle pulse coinciding with those states. sccb_wdata holds
    // the entry value for the whole entry and doubles as the compare reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tbl_idx    <= '0;
            sccb_req   <= 1'b0;
            sccb_wr    <= 1'b0;
            sccb_addr  <= '0;
            sccb_wdata <= '0;
            busy       <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            err_idx    <= '0;
            rdata_q    <= '0;
            retry      <= '0;
            dly_cnt    <= '0;
        end else begin
            sccb_req <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        cfg_done <= 1'b0;
                        cfg_err  <= 1'b0;
                        tbl_idx  <= '0;
                        retry    <= '0;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (tbl_data[15:8] == DLY_ADDR) begin
                        dly_cnt <= DLY_W'(tbl_data[7:0]) * DLY_W'(DLY_UNIT);
                        state   <= S_DELAY;
                    end else begin
                        sccb_addr  <= tbl_data[15:8];
                        sccb_wdata <= tbl_data[7:0];
                        sccb_req   <= 1'b1;
                        sccb_wr    <= 1'b1;
                        state      <= S_WR;
                    end
                end
                S_WR: state <= S_WR_WAIT;
                S_WR_WAIT: begin
                    if (sccb_done) begin
                        if (VERIFY_EN != 0) begin
                            sccb_req <= 1'b1;
                            sccb_wr  <= 1'b0;
                            state    <= S_RD;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_RD: state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (sccb_done) begin
                        rdata_q <= sccb_rdata;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (rdata_q == sccb_wdata) begin
                        state <= S_NEXT;
                    end else begin
                        retry <= retry + 3'd1;
                        if (retry + 3'd1 == RETRY_LIM) begin
                            err_idx <= tbl_idx;
                            cfg_err <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_ERR;
                        end else begin
                            sccb_req <= 1'b1;
                            sccb_wr  <= 1'b1;
                            state    <= S_WR;
                        end
                    end
                end
                // Occupies max(val*DLY_UNIT, 1) cycles.
                S_DELAY: begin
                    if (dly_cnt <= DLY_W'(1)) state <= S_NEXT;
                    else                      dly_cnt <= dly_cnt - DLY_W'(1);
                end
                S_NEXT: begin
                    if (tbl_idx == LAST_IDX) begin
                        cfg_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        tbl_idx <= tbl_idx + 8'd1;
                        retry   <= '0;
                        state   <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_sccb_cfg_seq
//   Two instances (readback enabled / disabled) share one SCCB slave model and
//   one 3-entry ROM. A vector table plus random tables are run; each pass is
//   compared against a transaction-list reference model.
// -----------------------------------------------------------------------------
module tb_sccb_cfg_seq;

    localparam int RETRY = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sel = 1'b0;
    initial forever #5 clk = ~clk;

    int unsigned cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    logic [15:0] rom [3];

    logic start_v, start_nv, done_r;
    logic [7:0] rdata_r;
    logic [7:0] tbl_idx_v, tbl_idx_nv, addr_v, addr_nv, wdata_v, wdata_nv, eidx_v, eidx_nv;
    logic [15:0] tbl_data_v, tbl_data_nv;
    logic req_v, req_nv, wr_v, wr_nv, done_v, done_nv;
    logic busy_v, busy_nv, cfgd_v, cfgd_nv, cfge_v, cfge_nv;

    assign start_v  = start & ~sel;
    assign start_nv = start & sel;
    assign done_v   = done_r & ~sel;
    assign done_nv  = done_r & sel;
    assign tbl_data_v  = (tbl_idx_v == 8'd0) ? rom[0] : (tbl_idx_v == 8'd1) ? rom[1] :
                         (tbl_idx_v == 8'd2) ? rom[2] : 16'h0000;
    assign tbl_data_nv = (tbl_idx_nv == 8'd0) ? rom[0] : (tbl_idx_nv == 8'd1) ? rom[1] :
                         (tbl_idx_nv == 8'd2) ? rom[2] : 16'h0000;

    sccb_cfg_seq #(.REG_NUM(3), .RETRY_MAX(3), .DLY_UNIT(10), .VERIFY_EN(1)) u_v (
        .clk(clk), .rst_n(rst_n), .start(start_v), .tbl_idx(tbl_idx_v), .tbl_data(tbl_data_v),
        .sccb_req(req_v), .sccb_wr(wr_v), .sccb_addr(addr_v), .sccb_wdata(wdata_v),
        .sccb_done(done_v), .sccb_rdata(rdata_r), .busy(busy_v), .cfg_done(cfgd_v),
        .cfg_err(cfge_v), .err_idx(eidx_v));

    sccb_cfg_seq #(.REG_NUM(3), .RETRY_MAX(3), .DLY_UNIT(10), .VERIFY_EN(0)) u_nv (
        .clk(clk), .rst_n(rst_n), .start(start_nv), .tbl_idx(tbl_idx_nv), .tbl_data(tbl_data_nv),
        .sccb_req(req_nv), .sccb_wr(wr_nv), .sccb_addr(addr_nv), .sccb_wdata(wdata_nv),
        .sccb_done(done_nv), .sccb_rdata(rdata_r), .busy(busy_nv), .cfg_done(cfgd_nv),
        .cfg_err(cfge_nv), .err_idx(eidx_nv));

    wire       m_req    = sel ? req_nv   : req_v;
    wire       m_wr     = sel ? wr_nv    : wr_v;
    wire [7:0] m_addr   = sel ? addr_nv  : addr_v;
    wire [7:0] m_wdata  = sel ? wdata_nv : wdata_v;
    wire       cur_done = sel ? cfgd_nv  : cfgd_v;
    wire       cur_err  = sel ? cfge_nv  : cfge_v;
    wire       cur_busy = sel ? busy_nv  : busy_v;
    wire [7:0] cur_eidx = sel ? eidx_nv  : eidx_v;

    typedef struct { logic wr; logic [7:0] addr; logic [7:0] data; } txn_t;
    txn_t got_q[$];
    txn_t exp_q[$];
    int unsigned req_cyc_q[$];
    int unsigned done_cyc_q[$];

    // ---------------- SCCB slave model ----------------
    logic [7:0]  mem [256];
    logic [15:0] fmask = '0;   // bit k set: k-th read of the pass returns a corrupted value
    int          rd_k = 0;
    bit          spur_en = 0;  // extra done pulse 3 cycles after each read completes
    bit          fix_lat = 0;
    bit          pend = 0;
    bit          cur_rd = 0;
    logic [7:0]  cur_addr = '0;
    int          lat_cnt = 0;
    int          spur_cnt = 0;

    initial begin
        done_r  = 1'b0;
        rdata_r = '0;
        forever begin
            @(negedge clk);
            done_r = 1'b0;
            if (spur_cnt > 0) begin
                spur_cnt = spur_cnt - 1;
                if (spur_cnt == 0) done_r = 1'b1;
            end
            if (pend) begin
                lat_cnt = lat_cnt - 1;
                if (lat_cnt == 0) begin
                    pend   = 0;
                    done_r = 1'b1;
                    done_cyc_q.push_back(cyc + 1);
                    if (cur_rd) begin
                        rdata_r = mem[cur_addr] ^ {7'd0, (rd_k < 16) ? fmask[rd_k] : 1'b0};
                        rd_k = rd_k + 1;
                        if (spur_en) spur_cnt = 3;
                    end else begin
                        rdata_r = 8'($urandom);
                    end
                end
            end else if (m_req) begin
                txn_t t;
                t.wr = m_wr; t.addr = m_addr; t.data = m_wdata;
                got_q.push_back(t);
                req_cyc_q.push_back(cyc);
                if (m_wr) mem[m_addr] = m_wdata;
                cur_rd   = !m_wr;
                cur_addr = m_addr;
                lat_cnt  = fix_lat ? 4 : int'($urandom_range(1, 4));
                pend     = 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each non-delay entry is attempted up to RETRY times; an
    // attempt is a write (plus a read when verifying) and fails only when its
    // read is marked corrupt.
    task automatic model(input logic [2:0][15:0] tbl, input logic [15:0] fm, input bit ver,
                         output bit d, output bit e, output logic [7:0] ei);
        int k = 0;
        txn_t t;
        exp_q.delete();
        d = 0; e = 0; ei = '0;
        for (int i = 0; i < 3; i++) begin
            bit ok = 0;
            if (tbl[i][15:8] == 8'hFF) continue;
            for (int a = 0; a < RETRY; a++) begin
                t.wr = 1'b1; t.addr = tbl[i][15:8]; t.data = tbl[i][7:0];
                exp_q.push_back(t);
                if (!ver) begin ok = 1; break; end
                t.wr = 1'b0;
                exp_q.push_back(t);
                k = k + 1;
                if (!fm[k-1]) begin ok = 1; break; end
            end
            if (!ok) begin
                e = 1; ei = 8'(i);
                return;
            end
        end
        d = 1;
    endtask

    typedef struct {
        logic [2:0][15:0] tbl;
        logic [15:0]      fmask;
        bit               nv;
        bit               spur;
        bit               sbusy;
        bit               exp_done;
        bit               exp_err;
        logic [7:0]       exp_eidx;
        int               exp_nreq;   // -1: outcome taken from the model only
    } vec_t;

    function automatic vec_t mk(logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] fm,
                                bit nv, bit sp, bit sb, bit ed, bit ee, logic [7:0] ei, int n);
        vec_t r;
        r.tbl = {c, b, a};
        r.fmask = fm; r.nv = nv; r.spur = sp; r.sbusy = sb;
        r.exp_done = ed; r.exp_err = ee; r.exp_eidx = ei; r.exp_nreq = n;
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        bit md, me;
        logic [7:0] mei;
        bit ed, ee;
        logic [7:0] ei;
        bit finished = 0;
        sel = v.nv;
        for (int i = 0; i < 3; i++) rom[i] = v.tbl[i];
        fmask = v.fmask; spur_en = v.spur; rd_k = 0;
        got_q.delete(); req_cyc_q.delete(); done_cyc_q.delete();
        model(v.tbl, v.fmask, !v.nv, md, me, mei);
        if (v.exp_nreq >= 0) begin ed = v.exp_done; ee = v.exp_err; ei = v.exp_eidx; end
        else begin ed = md; ee = me; ei = mei; end

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({nm, ".busy_rise"}, 32'(cur_busy), 32'd1);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (cur_done || cur_err) begin finished = 1; break; end
            if (v.sbusy && (n % 7 == 3)) start = 1'b1;
        end
        chk({nm, ".finished"}, 32'(finished), 32'd1);
        chk({nm, ".cfg_done"}, 32'(cur_done), 32'(ed));
        chk({nm, ".cfg_err"}, 32'(cur_err), 32'(ee));
        chk({nm, ".busy_end"}, 32'(cur_busy), 32'd0);
        if (ee) chk({nm, ".err_idx"}, 32'(cur_eidx), 32'(ei));
        if (v.exp_nreq >= 0) chk({nm, ".nreq"}, 32'(got_q.size()), 32'(v.exp_nreq));
        chk({nm, ".nreq_model"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
            chk($sformatf("%s.txn%0d", nm, j),
                {15'd0, got_q[j].wr, got_q[j].addr, got_q[j].data},
                {15'd0, exp_q[j].wr, exp_q[j].addr, exp_q[j].data});
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, ".tbl_idx"}, 32'(tbl_idx_v), 32'd0);
        chk({nm, ".req"}, 32'(req_v), 32'd0);
        chk({nm, ".wr"}, 32'(wr_v), 32'd0);
        chk({nm, ".addr"}, 32'(addr_v), 32'd0);
        chk({nm, ".wdata"}, 32'(wdata_v), 32'd0);
        chk({nm, ".busy"}, 32'(busy_v), 32'd0);
        chk({nm, ".cfg_done"}, 32'(cfgd_v), 32'd0);
        chk({nm, ".cfg_err"}, 32'(cfge_v), 32'd0);
        chk({nm, ".err_idx"}, 32'(eidx_v), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_rd = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        //                 e0        e1        e2        fmask     nv sp sb done err eidx nreq
        vecs[0] = mk(16'h1100, 16'h1204, 16'h4010, 16'h0000, 0, 0, 0, 1, 0, 8'd0, 6);
        vecs[1] = mk(16'h1100, 16'h1204, 16'h4010, 16'h000E, 0, 0, 0, 0, 1, 8'd1, 8);
        vecs[2] = mk(16'h1100, 16'h1204, 16'h4010, 16'h0002, 0, 0, 0, 1, 0, 8'd0, 8);
        vecs[3] = mk(16'h1280, 16'hFF03, 16'h1100, 16'h0000, 1, 0, 0, 1, 0, 8'd0, 2);
        vecs[4] = mk(16'h1100, 16'h1204, 16'h4010, 16'h0000, 0, 1, 1, 1, 0, 8'd0, 6);
        vecs[5] = mk(16'h1100, 16'h1204, 16'h4010, 16'h001C, 0, 0, 0, 0, 1, 8'd2, 10);
        vecs[6] = mk(16'h1100, 16'h1204, 16'h4010, 16'h0003, 0, 0, 0, 1, 0, 8'd0, 10);

        repeat (3) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 3) begin
                // Write-only gap between entries is 2 cycles (NEXT, LOAD);
                // the 3-tick delay entry adds LOAD + 30 DELAY + NEXT.
                if (done_cyc_q.size() >= 1 && req_cyc_q.size() >= 2)
                    chk("dly.gap", 32'(req_cyc_q[1] - done_cyc_q[0]), 32'd34);
                else
                    chk("dly.gap_avail", 32'(req_cyc_q.size()), 32'd2);
            end
        end

        // Reset while waiting for a readback.
        sel = 0; fix_lat = 1; fmask = '0; spur_en = 0; rd_k = 0;
        rom[0] = 16'h1100; rom[1] = 16'h1204; rom[2] = 16'h4010;
        got_q.delete(); req_cyc_q.delete(); done_cyc_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (got_q.size() >= 2) begin seen_rd = 1; break; end
            @(negedge clk);
        end
        chk("rst.rd_issued", 32'(seen_rd), 32'd1);
        if (got_q.size() >= 2) chk("rst.second_is_read", 32'(got_q[1].wr), 32'd0);
        @(posedge clk);
        chk("rst.busy_before", 32'(busy_v), 32'd1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset("rst_mid");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        fix_lat = 0;
        run_vec(vecs[0], "after_rst");

        for (int r = 0; r < 25; r++) begin
            logic [15:0] e [3];
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 4) == 0) e[i] = {8'hFF, 8'($urandom_range(0, 3))};
                else e[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
            end
            run_vec(mk(e[0], e[1], e[2], 16'($urandom & $urandom), ($urandom_range(0, 3) == 0),
                       0, 0, 0, 0, 8'd0, -1), $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
